conv_layer_sched: RTL and testbench

//  Sequencer for one conv output tile. Per input channel it fetches the 80-bit weight/bias word

---
 rtl/conv_layer_sched.sv | 168 ++++++++++++++++
 tb/tb_conv_layer_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sched.sv
// Tile sequencer for one conv output tile: per-channel parameter fetch, row-group
// window streaming, PE drain, then OFM send handshake.
//
// state  | meaning
// IDLE   | waiting for i_start
// LOAD   | param RAM read issued for ic_cnt
// WAIT   | RAM latency, capture word on exit
// LATCH  | o_params_valid strobe to conv
// STREAM | window beats accepted, col_cnt counts
// ROWEND | row group complete, pick next group/channel
// DRAIN  | let PE pipeline and sum regs empty
// SEND   | o_send_flg strobe
// TXWAIT | wait for last AXIS beat
// DONE   | o_done strobe
module conv_layer_sched #(
  parameter int IMG_W      = 48,
  parameter int ROW_GROUPS = 16,
  parameter int NUM_IC     = 32,
  parameter int DRAIN_CYC  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_param_rd,
  output logic [5:0]  o_param_addr,
  input  logic [79:0] i_param_q,
  output logic [79:0] o_params,
  output logic        o_params_valid,
  output logic [5:0]  o_current_ic,
  output logic        o_win_req,
  input  logic        i_win_valid,
  output logic        o_row_done,
  output logic        o_send_flg,
  input  logic        i_tx_last
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(ROW_GROUPS + 1);
  localparam int DW = $clog2(DRAIN_CYC + 1);

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROW_GROUPS - 1);
  localparam logic [5:0]    IC_LAST    = 6'(NUM_IC - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WAIT, S_LATCH, S_STREAM,
    S_ROWEND, S_DRAIN, S_SEND, S_TXWAIT, S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [5:0]    ic_cnt;
  logic [DW-1:0] drain_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      col_cnt        <= '0;
      row_cnt        <= '0;
      ic_cnt         <= '0;
      drain_cnt      <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      o_param_rd     <= 1'b0;
      o_param_addr   <= '0;
      o_params       <= '0;
      o_params_valid <= 1'b0;
      o_current_ic   <= '0;
      o_win_req      <= 1'b0;
      o_row_done     <= 1'b0;
      o_send_flg     <= 1'b0;
    end else begin
      o_param_rd     <= 1'b0;
      o_params_valid <= 1'b0;
      o_row_done     <= 1'b0;
      o_send_flg     <= 1'b0;
      o_done         <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_start) begin
            state        <= S_LOAD;
            o_busy       <= 1'b1;
            o_err        <= 1'b0;
            o_param_rd   <= 1'b1;
            o_param_addr <= '0;
            o_current_ic <= '0;
            ic_cnt       <= '0;
            row_cnt      <= '0;
            col_cnt      <= '0;
            drain_cnt    <= '0;
          end
        end
        S_LOAD: state <= S_WAIT;
        S_WAIT: begin
          o_params       <= i_param_q;
          o_params_valid <= 1'b1;
          state          <= S_LATCH;
        end
        S_LATCH: begin
          o_win_req <= 1'b1;
          state     <= S_STREAM;
        end
        S_STREAM: begin
          if (i_win_valid) begin
            if (col_cnt == COL_LAST) begin
              col_cnt    <= '0;
              o_win_req  <= 1'b0;
              o_row_done <= 1'b1;
              state      <= S_ROWEND;
            end else begin
              col_cnt <= col_cnt + CW'(1);
            end
          end
        end
        S_ROWEND: begin
          if (row_cnt != ROW_LAST) begin
            row_cnt   <= row_cnt + RW'(1);
            o_win_req <= 1'b1;
            state     <= S_STREAM;
          end else begin
            row_cnt <= '0;
            if (ic_cnt != IC_LAST) begin
              ic_cnt       <= ic_cnt + 6'd1;
              o_param_addr <= ic_cnt + 6'd1;
              o_current_ic <= ic_cnt + 6'd1;
              o_param_rd   <= 1'b1;
              state        <= S_LOAD;
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt  <= '0;
            o_send_flg <= 1'b1;
            state      <= S_SEND;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        S_SEND: state <= S_TXWAIT;
        S_TXWAIT: begin
          if (i_tx_last) begin
            o_done <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // A stray beat is an error even in the cycle a new tile is accepted
      if (i_win_valid && state != S_STREAM) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Scoreboard bench: a small-geometry instance and a default-geometry instance,
// each checked against a per-tile event list built from the sequencing rules.
module tb_conv_layer_sched;

  localparam int DR = 4;

  typedef enum int {EV_RD, EV_PV, EV_ROW, EV_SEND, EV_DONE} ev_kind_t;
  typedef struct {
    int          inst;
    int          kind;
    int          ic;
    logic [79:0] p;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m_start [2];
  logic        n_start [2];
  logic        start   [2];
  logic        agent_v [2];
  logic        force_v [2];
  logic        win_valid [2];
  logic        tx_last [2];
  logic [79:0] param_q [2];
  logic        busy [2], done [2], err [2], param_rd [2], params_valid [2];
  logic        win_req [2], row_done [2], send_flg [2];
  logic [5:0]  param_addr [2], current_ic [2];
  logic [79:0] params [2];

  logic [79:0] mem [2][64];
  int          pct [2];
  int          rows_seen [2], pv_seen [2], send_seen [2];
  int          cyc = 0;
  ev_t         sb [$];
  int          total = 0;
  int          bad = 0;

  conv_layer_sched #(.IMG_W(4), .ROW_GROUPS(2), .NUM_IC(2), .DRAIN_CYC(DR)) dut_s (
    .clk(clk), .rst(rst), .i_start(start[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_err(err[0]), .o_param_rd(param_rd[0]), .o_param_addr(param_addr[0]),
    .i_param_q(param_q[0]), .o_params(params[0]), .o_params_valid(params_valid[0]),
    .o_current_ic(current_ic[0]), .o_win_req(win_req[0]), .i_win_valid(win_valid[0]),
    .o_row_done(row_done[0]), .o_send_flg(send_flg[0]), .i_tx_last(tx_last[0])
  );

  conv_layer_sched dut_d (
    .clk(clk), .rst(rst), .i_start(start[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_err(err[1]), .o_param_rd(param_rd[1]), .o_param_addr(param_addr[1]),
    .i_param_q(param_q[1]), .o_params(params[1]), .o_params_valid(params_valid[1]),
    .o_current_ic(current_ic[1]), .o_win_req(win_req[1]), .i_win_valid(win_valid[1]),
    .o_row_done(row_done[1]), .o_send_flg(send_flg[1]), .i_tx_last(tx_last[1])
  );

  function automatic int nic_of(input int k);
    return (k == 0) ? 2 : 32;
  endfunction
  function automatic int rg_of(input int k);
    return (k == 0) ? 2 : 16;
  endfunction
  function automatic int iw_of(input int k);
    return (k == 0) ? 4 : 48;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: one tile is, per channel, a read and a load of that channel's word
  // followed by one row-done per row group; then one send and one done.
  task automatic push_tile(input int k);
    ev_t e;
    e.inst = k;
    for (int ic = 0; ic < nic_of(k); ic++) begin
      e.ic = ic;
      e.kind = EV_RD;  e.p = '0;         sb.push_back(e);
      e.kind = EV_PV;  e.p = mem[k][ic]; sb.push_back(e);
      e.p = '0;
      for (int r = 0; r < rg_of(k); r++) begin
        e.kind = EV_ROW; sb.push_back(e);
      end
    end
    e.ic = nic_of(k) - 1;
    e.kind = EV_SEND; sb.push_back(e);
    e.kind = EV_DONE; sb.push_back(e);
  endtask

  task automatic expect_ev(input int k, input int kind, input int ic, input logic [79:0] p,
                           input string nm);
    ev_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: dut%0d produced event %0d, expected none", nm, k, kind);
    end else begin
      e = sb.pop_front();
      check({nm, "_kind"}, 80'(kind), (e.inst == k) ? 80'(e.kind) : 80'(99));
      if (e.inst == k && e.kind == kind) begin
        if (kind == EV_RD || kind == EV_PV) check({nm, "_ic"}, 80'(ic), 80'(e.ic));
        if (kind == EV_PV) check({nm, "_word"}, p, e.p);
      end
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    int beats;
    int beats_snap;
    int last_row_cyc;
    int tx_wait;
    bit in_tx;
    bit exp_done;

    assign start[g]     = m_start[g] | n_start[g];
    assign win_valid[g] = agent_v[g] | force_v[g];

    always @(posedge clk) begin
      if (param_rd[g]) param_q[g] <= mem[g][param_addr[g]];
      if (rst) beats <= 0;
      else if (win_valid[g] && win_req[g]) beats <= beats + 1;
    end

    // monitor
    always @(negedge clk) begin
      if (rst) begin
        beats_snap = 0;
      end else begin
        if (param_rd[g]) expect_ev(g, EV_RD, param_addr[g], '0, "param_rd");
        if (params_valid[g]) begin
          pv_seen[g]++;
          expect_ev(g, EV_PV, current_ic[g], params[g], "params_valid");
        end
        if (row_done[g]) begin
          rows_seen[g]++;
          expect_ev(g, EV_ROW, 0, '0, "row_done");
          check("beats_per_group", 80'(beats - beats_snap), 80'(iw_of(g)));
          beats_snap = beats;
          last_row_cyc = cyc;
        end
        if (send_flg[g]) begin
          send_seen[g]++;
          expect_ev(g, EV_SEND, 0, '0, "send_flg");
          check("send_delay", 80'(cyc - last_row_cyc), 80'(DR + 1));
        end
        if (done[g]) expect_ev(g, EV_DONE, 0, '0, "done");
      end
    end

    // agent: window beats, AXIS completion, ignored noise on i_start/i_tx_last
    always @(negedge clk) begin
      if (rst) begin
        agent_v[g] = 1'b0;
        n_start[g] = 1'b0;
        tx_last[g] = 1'b0;
        in_tx = 1'b0;
        exp_done = 1'b0;
      end else begin
        if (exp_done) begin
          check("done_after_tx_last", 80'(done[g]), 80'(1));
          exp_done = 1'b0;
        end
        tx_last[g] = 1'b0;
        if (send_flg[g]) begin
          in_tx = 1'b1;
          tx_wait = $urandom_range(0, 3);
        end else if (in_tx) begin
          if (tx_wait == 0) begin
            tx_last[g] = 1'b1;
            in_tx = 1'b0;
            exp_done = 1'b1;
          end else begin
            tx_wait--;
          end
        end else if (busy[g] && $urandom_range(0, 19) == 0) begin
          tx_last[g] = 1'b1;
        end
        n_start[g] = busy[g] && ($urandom_range(0, 15) == 0);
        agent_v[g] = win_req[g] && ($urandom_range(0, 99) < pct[g]);
      end
    end
  end

  task automatic check_zero(input int k, input string nm);
    check({nm, "_ctl"}, 80'({busy[k], done[k], err[k], param_rd[k], params_valid[k],
                             win_req[k], row_done[k], send_flg[k]}), 80'(0));
    check({nm, "_ic"}, 80'({param_addr[k], current_ic[k]}), 80'(0));
    check({nm, "_params"}, params[k], 80'(0));
  endtask

  task automatic start_tile(input int k);
    push_tile(k);
    m_start[k] = 1'b1;
    @(negedge clk);
    m_start[k] = 1'b0;
    check("busy_after_start", 80'(busy[k]), 80'(1));
    check("rd_after_start", 80'(param_rd[k]), 80'(1));
  endtask

  task automatic wait_idle(input int k, input int budget, input string nm);
    int n;
    n = 0;
    while (busy[k] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_finished"}, 80'(busy[k]), 80'(0));
  endtask

  function automatic logic [79:0] rnd80();
    return {$urandom, $urandom, 16'($urandom)};
  endfunction

  initial begin
    int n, r0, p0, s0;
    for (int k = 0; k < 2; k++) begin
      m_start[k] = 1'b0;
      force_v[k] = 1'b0;
      pct[k] = 100;
      rows_seen[k] = 0;
      pv_seen[k] = 0;
      send_seen[k] = 0;
      for (int a = 0; a < 64; a++) mem[k][a] = rnd80();
    end
    mem[0][1] = 80'hA5_010203040506070809;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero(0, "in_reset_s");
    check_zero(1, "in_reset_d");
    rst = 1'b0;
    @(negedge clk);
    check_zero(0, "after_reset_s");
    check_zero(1, "after_reset_d");

    // Run 1: back-to-back beats, stray beat injected in the second LOAD
    start_tile(0);
    check("err_clear_run1", 80'(err[0]), 80'(0));
    @(negedge clk);
    @(negedge clk);
    check("first_params_valid_latency", 80'(params_valid[0]), 80'(1));
    n = 0;
    while (!(param_rd[0] && param_addr[0] == 6'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_load_ic1", 80'(param_rd[0]), 80'(1));
    force_v[0] = 1'b1;
    @(negedge clk);
    force_v[0] = 1'b0;
    check("err_set_by_stray_beat", 80'(err[0]), 80'(1));
    wait_idle(0, 2000, "run1");
    check("err_sticky", 80'(err[0]), 80'(1));

    // Run 2: gapped beats, error cleared by the accepted start
    pct[0] = 33;
    mem[0][0] = rnd80();
    start_tile(0);
    check("err_cleared_by_start", 80'(err[0]), 80'(0));
    wait_idle(0, 4000, "run2");

    // Run 3: reset while streaming
    pct[0] = 100;
    start_tile(0);
    n = 0;
    while (!win_req[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reached_stream", 80'(win_req[0]), 80'(1));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_zero(0, "mid_reset");
    end
    sb.delete();
    rst = 1'b0;
    @(negedge clk);
    check_zero(0, "after_mid_reset");

    // Run 4: default geometry, full tile
    pct[1] = 100;
    r0 = rows_seen[1];
    p0 = pv_seen[1];
    s0 = send_seen[1];
    start_tile(1);
    wait_idle(1, 40000, "run_default");
    check("default_row_done_count", 80'(rows_seen[1] - r0), 80'(512));
    check("default_params_valid_count", 80'(pv_seen[1] - p0), 80'(32));
    check("default_send_count", 80'(send_seen[1] - s0), 80'(1));

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 80'(sb.size()), 80'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
